// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory interface: FSM encodings and default sizes.
package mem_pkg;

    // Default data-path widths and data-memory depth (in 64-bit words).
    localparam int unsigned DMEM_DATA_W = 64;
    localparam int unsigned DMEM_ADDR_W = 64;
    localparam int unsigned DMEM_SIZE   = 64;

    // Width of the wait-state counter; bounds WAIT_CYCLES to 1..15.
    localparam int unsigned MAU_CNT_W   = 4;
    localparam int unsigned MAU_WAIT_MAX = 15;

    // Access-unit FSM states.
    typedef enum logic [1:0] {
        MAU_IDLE   = 2'd0,
        MAU_ACCESS = 2'd1,
        MAU_RESP   = 2'd2
    } mau_state_e;

endpackage : mem_pkg

// File: rtl/mem_access_unit.sv
// Initiator for the data memory: takes one load/store at a time from the MEM
// stage, drives the memory pins for WAIT_CYCLES cycles and returns the result.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MEM_SIZE    = DMEM_SIZE,
    parameter int unsigned DATA_W      = DMEM_DATA_W,
    parameter int unsigned ADDR_W      = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = MAU_CNT_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_SIZE);

    // Counter is only 4 bits and a zero wait count has no ACCESS cycle to strobe in.
    if (WAIT_CYCLES == 0 || WAIT_CYCLES > MAU_WAIT_MAX) begin : g_wait_cycles_illegal
        $error("mem_access_unit: WAIT_CYCLES=%0d outside legal range 1..%0d",
               WAIT_CYCLES, MAU_WAIT_MAX);
    end

    // ------------------------------------------------------------------
    // State, counter and latched request
    // ------------------------------------------------------------------
    mau_state_e        r_state;
    mau_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic              r_write;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_addr_oob;
    logic              w_last;

    // Request fields as they will be after the coming edge.
    logic              w_nxt_write;
    logic              w_nxt_err;
    logic [ADDR_W-1:0] w_nxt_addr;
    logic [DATA_W-1:0] w_nxt_wdata;
    logic              w_nxt_access;

    // Next values of the registered outputs.
    logic              w_req_ready_nxt;
    logic              w_resp_valid_nxt;
    logic [DATA_W-1:0] w_resp_rdata_nxt;
    logic              w_resp_err_nxt;
    logic [ADDR_W-1:0] w_mem_address_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic              w_mem_read_nxt;
    logic              w_mem_write_nxt;

    assign w_accept   = (r_state == MAU_IDLE) && req_valid;
    assign w_addr_oob = (req_addr >= ADDR_LIMIT);
    assign w_last     = (r_state == MAU_ACCESS) && (r_cnt == CNT_W'(0));

    // State and wait counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MAU_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter decode. An out-of-range request spends one
    // ACCESS cycle with the memory pins idle so it answers one edge later.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            MAU_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = MAU_ACCESS;
                    w_cnt_nxt   = w_addr_oob ? CNT_W'(0) : CNT_INIT;
                end
            end
            MAU_ACCESS: begin
                if (r_cnt == CNT_W'(0)) begin
                    w_state_nxt = MAU_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            MAU_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = MAU_IDLE;
                end
            end
            default: begin
                w_state_nxt = MAU_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Latch the request on the accepting edge; held for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_err   <= w_addr_oob;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Output decode from next state and next request fields, so every pin
    // comes straight off a flop with no comb path from req_* to mem_*.
    always_comb begin
        w_nxt_write  = w_accept ? req_write  : r_write;
        w_nxt_err    = w_accept ? w_addr_oob : r_err;
        w_nxt_addr   = w_accept ? req_addr   : r_addr;
        w_nxt_wdata  = w_accept ? req_wdata  : r_wdata;
        w_nxt_access = (w_state_nxt == MAU_ACCESS) && !w_nxt_err;

        w_req_ready_nxt   = (w_state_nxt == MAU_IDLE);
        w_resp_valid_nxt  = (w_state_nxt == MAU_RESP);
        w_mem_read_nxt    = w_nxt_access && !w_nxt_write;
        w_mem_write_nxt   = w_nxt_access && w_nxt_write && (w_cnt_nxt == CNT_W'(0));
        w_mem_address_nxt = w_nxt_access ? w_nxt_addr : '0;
        w_mem_wdata_nxt   = (w_nxt_access && w_nxt_write) ? w_nxt_wdata : '0;

        w_resp_rdata_nxt  = resp_rdata;
        w_resp_err_nxt    = resp_err;
        if (w_last) begin
            w_resp_rdata_nxt = (r_write || r_err) ? '0 : mem_rdata;
            w_resp_err_nxt   = r_err;
        end else if (w_accept) begin
            w_resp_rdata_nxt = '0;
            w_resp_err_nxt   = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
        end else begin
            req_ready   <= w_req_ready_nxt;
            resp_valid  <= w_resp_valid_nxt;
            resp_rdata  <= w_resp_rdata_nxt;
            resp_err    <= w_resp_err_nxt;
            mem_address <= w_mem_address_nxt;
            mem_wdata   <= w_mem_wdata_nxt;
            mem_read    <= w_mem_read_nxt;
            mem_write   <= w_mem_write_nxt;
        end
    end

endmodule : mem_access_unit
